// File: rtl/pipelined_mux_n_if.sv
// Handshake/bus bundle for pipelined_mux_n: input beat, control, and
// registered result. master drives beats, slave is the mux.
interface pipelined_mux_n_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = 2
);
  logic [N*WIDTH-1:0] in_bus;
  logic [SELW-1:0]    sel;
  logic               in_valid;
  logic               stall;
  logic               flush;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic               sel_err;
  logic [7:0]         err_count;

  modport master (
    output in_bus, sel, in_valid, stall, flush,
    input  out, out_valid, sel_err, err_count
  );

  modport slave (
    input  in_bus, sel, in_valid, stall, flush,
    output out, out_valid, sel_err, err_count
  );
endinterface

// File: rtl/pipelined_mux_n.sv
// Registered N:1 word mux with 1 or 2 pipeline stages, stall/flush,
// valid tag, out-of-range select flag and saturating error counter.
module pipelined_mux_n #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N        = 4,
  parameter int unsigned SELW     = 2,
  parameter int unsigned STAGES   = 1,
  parameter bit          OOR_ZERO = 1'b1
) (
  input logic               Clk,
  input logic               Reset,
  pipelined_mux_n_if.slave  bus
);

  if (STAGES < 1 || STAGES > 2) begin : g_bad_stages
    $error("pipelined_mux_n: STAGES must be 1 or 2");
  end
  if ((2 ** SELW) < N) begin : g_bad_selw
    $error("pipelined_mux_n: 2**SELW must be >= N");
  end
  if (N < 2 || N > 16) begin : g_bad_n
    $error("pipelined_mux_n: N must be in 2..16");
  end

  logic [WIDTH-1:0] w_word;
  logic             w_in_range;
  logic [WIDTH-1:0] r_d1;
  logic             r_v1;
  logic             r_e1;
  logic [7:0]       r_cnt;

  // Select the addressed word; only meaningful when sel is in range.
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.sel == SELW'(i)) w_word = bus.in_bus[i*WIDTH +: WIDTH];
    end
  end

  // One extra bit so the compare stays correct when N == 2**SELW.
  assign w_in_range = ({1'b0, bus.sel} < (SELW+1)'(N));

  // Stage 1 and error counter: Reset > flush > stall > advance.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_d1  <= '0;
      r_v1  <= 1'b0;
      r_e1  <= 1'b0;
      r_cnt <= '0;
    end else if (bus.flush) begin
      r_d1 <= '0;
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
    end else if (!bus.stall) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        if (w_in_range) begin
          r_d1 <= w_word;
          r_e1 <= 1'b0;
        end else begin
          r_e1 <= 1'b1;
          if (OOR_ZERO) r_d1 <= '0;
          if (r_cnt != '1) r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  if (STAGES == 2) begin : g_s2
    logic [WIDTH-1:0] r_d2;
    logic             r_v2;
    logic             r_e2;

    // Stage 2: straight copy of stage 1 under the same control priority.
    always_ff @(posedge Clk) begin
      if (Reset || bus.flush) begin
        r_d2 <= '0;
        r_v2 <= 1'b0;
        r_e2 <= 1'b0;
      end else if (!bus.stall) begin
        r_d2 <= r_d1;
        r_v2 <= r_v1;
        r_e2 <= r_e1;
      end
    end

    assign bus.out       = r_d2;
    assign bus.out_valid = r_v2;
    assign bus.sel_err   = r_e2;
  end else begin : g_s1
    assign bus.out       = r_d1;
    assign bus.out_valid = r_v1;
    assign bus.sel_err   = r_e1;
  end

  assign bus.err_count = r_cnt;

endmodule

// File: tb/tb_pipelined_mux_n.sv
// Bench for pipelined_mux_n: four configurations driven with the same
// stimulus, each compared against a beat-level reference model.
//   0: N=4 STAGES=1 OOR_ZERO=1   1: N=4 STAGES=2 OOR_ZERO=1
//   2: N=3 STAGES=1 OOR_ZERO=1   3: N=3 STAGES=2 OOR_ZERO=0
module tb_pipelined_mux_n;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] w [4];
  logic        in_v = 1'b0;
  logic [1:0]  in_s = '0;
  logic        in_st = 1'b0;
  logic        in_fl = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  pipelined_mux_n_if #(.WIDTH(32), .N(4), .SELW(2)) if0 ();
  pipelined_mux_n_if #(.WIDTH(32), .N(4), .SELW(2)) if1 ();
  pipelined_mux_n_if #(.WIDTH(32), .N(3), .SELW(2)) if2 ();
  pipelined_mux_n_if #(.WIDTH(32), .N(3), .SELW(2)) if3 ();

  assign if0.in_bus = {w[3], w[2], w[1], w[0]};
  assign if1.in_bus = {w[3], w[2], w[1], w[0]};
  assign if2.in_bus = {w[2], w[1], w[0]};
  assign if3.in_bus = {w[2], w[1], w[0]};
  assign {if0.sel, if1.sel, if2.sel, if3.sel} = {4{in_s}};
  assign {if0.in_valid, if1.in_valid, if2.in_valid, if3.in_valid} = {4{in_v}};
  assign {if0.stall, if1.stall, if2.stall, if3.stall} = {4{in_st}};
  assign {if0.flush, if1.flush, if2.flush, if3.flush} = {4{in_fl}};

  pipelined_mux_n #(.WIDTH(32), .N(4), .SELW(2), .STAGES(1), .OOR_ZERO(1'b1))
    u_d0 (.Clk(Clk), .Reset(Reset), .bus(if0));
  pipelined_mux_n #(.WIDTH(32), .N(4), .SELW(2), .STAGES(2), .OOR_ZERO(1'b1))
    u_d1 (.Clk(Clk), .Reset(Reset), .bus(if1));
  pipelined_mux_n #(.WIDTH(32), .N(3), .SELW(2), .STAGES(1), .OOR_ZERO(1'b1))
    u_d2 (.Clk(Clk), .Reset(Reset), .bus(if2));
  pipelined_mux_n #(.WIDTH(32), .N(3), .SELW(2), .STAGES(2), .OOR_ZERO(1'b0))
    u_d3 (.Clk(Clk), .Reset(Reset), .bus(if3));

  logic [31:0] o_out [4];
  logic        o_v   [4];
  logic        o_e   [4];
  logic [7:0]  o_c   [4];
  assign o_out[0] = if0.out; assign o_v[0] = if0.out_valid; assign o_e[0] = if0.sel_err; assign o_c[0] = if0.err_count;
  assign o_out[1] = if1.out; assign o_v[1] = if1.out_valid; assign o_e[1] = if1.sel_err; assign o_c[1] = if1.err_count;
  assign o_out[2] = if2.out; assign o_v[2] = if2.out_valid; assign o_e[2] = if2.sel_err; assign o_c[2] = if2.err_count;
  assign o_out[3] = if3.out; assign o_v[3] = if3.out_valid; assign o_e[3] = if3.sel_err; assign o_c[3] = if3.err_count;

  // Reference model: per configuration, a list of beat slots (slot 0 is
  // the newest) plus an error tally.
  int unsigned cfg_n  [4] = '{4, 4, 3, 3};
  int unsigned cfg_st [4] = '{1, 2, 1, 2};
  bit          cfg_oz [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] m_d [4][2];
  bit          m_v [4][2];
  bit          m_e [4][2];
  int          m_cnt [4];

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      if (Reset || in_fl) begin
        for (int j = 0; j < 2; j++) begin
          m_d[k][j] = '0; m_v[k][j] = 1'b0; m_e[k][j] = 1'b0;
        end
        if (Reset) m_cnt[k] = 0;
      end else if (!in_st) begin
        m_d[k][1] = m_d[k][0]; m_v[k][1] = m_v[k][0]; m_e[k][1] = m_e[k][0];
        m_v[k][0] = in_v;
        if (in_v) begin
          if (int'(in_s) < int'(cfg_n[k])) begin
            m_d[k][0] = w[in_s];
            m_e[k][0] = 1'b0;
          end else begin
            m_e[k][0] = 1'b1;
            if (cfg_oz[k]) m_d[k][0] = '0;
            if (m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
  endtask

  function automatic logic [31:0] exp_d(int k); return m_d[k][cfg_st[k]-1]; endfunction
  function automatic bit exp_v(int k); return m_v[k][cfg_st[k]-1]; endfunction
  function automatic bit exp_e(int k); return m_e[k][cfg_st[k]-1]; endfunction

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input bit v, input logic [1:0] s, input bit st, input bit fl);
    in_v = v; in_s = s; in_st = st; in_fl = fl;
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0);
    Reset = 1'b1;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_out[k] !== 32'h0 || o_v[k] !== 1'b0 || o_e[k] !== 1'b0 || o_c[k] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got out=%h v=%b e=%b cnt=%0d, want 0 0 0 0",
                 k, o_out[k], o_v[k], o_e[k], o_c[k]);
      end
    end
    Reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_v[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_valid dut%0d: got %b want 0", k, o_v[k]);
      end
    end
  endtask

  task automatic test_basic_select();
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] want;
      set_in(1, 2'(i % 4), 0, 0);
      want = 32'h11111111 * 32'((i % 4) + 1);
      tick();
      n_checks++;
      if (o_out[0] !== want || o_v[0] !== 1'b1 || o_e[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_select sel=%0d: got out=%h v=%b e=%b, want %h 1 0",
                 i % 4, o_out[0], o_v[0], o_e[0], want);
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (o_out[k] !== exp_d(k) || o_v[k] !== exp_v(k) || o_e[k] !== exp_e(k) || o_c[k] !== 8'(m_cnt[k])) begin
          n_fail++;
          $display("FAIL basic_model dut%0d: got %h %b %b %0d, want %h %b %b %0d",
                   k, o_out[k], o_v[k], o_e[k], o_c[k], exp_d(k), exp_v(k), exp_e(k), m_cnt[k]);
        end
      end
    end
  endtask

  task automatic test_stall_latency();
    set_in(0, 0, 0, 1); tick();           // empty the pipes
    set_in(1, 2, 0, 0); tick();           // cycle 0: accept sel=2
    n_checks++;
    if (o_v[1] !== 1'b0) begin n_fail++; $display("FAIL lat_c0 valid: got %b want 0", o_v[1]); end
    set_in(1, 3, 1, 0);                   // sel=3 beat offered while stalled
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_checks++;
      if (o_v[1] !== 1'b0) begin n_fail++; $display("FAIL lat_stall_c%0d valid: got %b want 0", c, o_v[1]); end
    end
    set_in(0, 0, 0, 0); tick();
    n_checks++;
    if (o_out[1] !== 32'h33333333 || o_v[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_emerge: got out=%h v=%b, want 33333333 1", o_out[1], o_v[1]);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (o_v[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL stalled_beat_lost: got v=%b out=%h, want v=0", o_v[1], o_out[1]);
      end
    end
  endtask

  task automatic test_flush();
    int cnt_before;
    set_in(1, 0, 0, 0); tick();
    set_in(1, 1, 0, 0); tick();
    cnt_before = m_cnt[2];
    set_in(1, 3, 1, 1); tick();           // flush together with stall
    n_checks++;
    if (o_v[1] !== 1'b0 || o_out[1] !== 32'h0 || o_e[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stage2: got out=%h v=%b e=%b, want 0 0 0", o_out[1], o_v[1], o_e[1]);
    end
    n_checks++;
    if (o_c[2] !== 8'(cnt_before)) begin
      n_fail++;
      $display("FAIL flush_err_count: got %0d want %0d", o_c[2], cnt_before);
    end
    set_in(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (o_v[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL flushed_beat_emerged dut%0d: got v=%b out=%h, want v=0", k, o_v[k], o_out[k]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    Reset = 1'b1; set_in(0, 0, 0, 0); tick(); Reset = 1'b0;
    set_in(1, 1, 0, 0); tick();
    set_in(1, 3, 0, 0); tick();
    n_checks++;
    if (o_out[2] !== 32'h0 || o_e[2] !== 1'b1 || o_c[2] !== 8'd1 || o_v[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_zero: got out=%h e=%b cnt=%0d v=%b, want 0 1 1 1", o_out[2], o_e[2], o_c[2], o_v[2]);
    end
    set_in(0, 0, 0, 0); tick();
    n_checks++;
    if (o_out[3] !== 32'h22222222 || o_e[3] !== 1'b1 || o_v[3] !== 1'b1 || o_c[3] !== 8'd1) begin
      n_fail++;
      $display("FAIL oor_hold: got out=%h e=%b v=%b cnt=%0d, want 22222222 1 1 1", o_out[3], o_e[3], o_v[3], o_c[3]);
    end
    n_checks++;
    if (o_c[0] !== 8'd0 || o_c[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL full_range_no_err: got cnt0=%0d cnt1=%0d, want 0 0", o_c[0], o_c[1]);
    end
  endtask

  task automatic test_saturation();
    set_in(1, 3, 0, 0);
    for (int i = 0; i < 300; i++) tick();
    n_checks++;
    if (o_c[2] !== 8'd255 || o_c[3] !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate: got cnt2=%0d cnt3=%0d, want 255 255", o_c[2], o_c[3]);
    end
    n_checks++;
    if (o_c[0] !== 8'd0 || o_e[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sel3_in_range_n4: got cnt=%0d e=%b, want 0 0", o_c[0], o_e[0]);
    end
    set_in(1, 0, 0, 0); tick();
    n_checks++;
    if (o_e[2] !== 1'b0 || o_out[2] !== 32'h11111111 || o_c[2] !== 8'd255) begin
      n_fail++;
      $display("FAIL after_saturate: got e=%b out=%h cnt=%0d, want 0 11111111 255", o_e[2], o_out[2], o_c[2]);
    end
  endtask

  task automatic test_reset_mid();
    Reset = 1'b1; set_in(0, 0, 0, 0); tick(); Reset = 1'b0;
    set_in(1, 3, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    set_in(1, 1, 0, 0); tick();
    set_in(1, 2, 0, 0); tick();
    n_checks++;
    if (o_c[2] !== 8'd5 || o_v[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: got cnt=%0d v1=%b, want 5 1", o_c[2], o_v[1]);
    end
    Reset = 1'b1; tick(); Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (o_out[k] !== 32'h0 || o_v[k] !== 1'b0 || o_e[k] !== 1'b0 || o_c[k] !== 8'd0) begin
        n_fail++;
        $display("FAIL mid_reset dut%0d: got %h %b %b %0d, want 0 0 0 0", k, o_out[k], o_v[k], o_e[k], o_c[k]);
      end
    end
    set_in(1, 2, 0, 0); tick();
    n_checks++;
    if (o_out[0] !== 32'h33333333 || o_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL resume: got out=%h v=%b, want 33333333 1", o_out[0], o_v[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      for (int j = 0; j < 4; j++) w[j] = $urandom;
      set_in(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
      Reset = ($urandom_range(0, 99) == 0);
      tick();
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (o_out[k] !== exp_d(k) || o_v[k] !== exp_v(k) || o_e[k] !== exp_e(k) || o_c[k] !== 8'(m_cnt[k])) begin
          n_fail++;
          $display("FAIL random_model cyc%0d dut%0d: got %h %b %b %0d, want %h %b %b %0d",
                   i, k, o_out[k], o_v[k], o_e[k], o_c[k], exp_d(k), exp_v(k), exp_e(k), m_cnt[k]);
        end
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 4; j++) w[j] = '0;
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0;
      for (int j = 0; j < 2; j++) begin m_d[k][j] = '0; m_v[k][j] = 1'b0; m_e[k][j] = 1'b0; end
    end
    test_reset();
    test_basic_select();
    test_stall_latency();
    test_flush();
    test_out_of_range();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_mux_n.md
Name: pipelined_mux_n

Overview:
- Parametrised, registered N:1 word multiplexer for the pipelined datapath, e.g. forwarding-path selection (EX/MEM/WB operand) and SAD-unit operand steering.
- Adds a configurable pipeline depth, stall/flush control, a valid tag that travels with the data, and out-of-range select detection with a saturating error counter.
- Sits between pipeline registers. Stall and flush are driven by the hazard unit.

Parameters:
- WIDTH, 32, data word width in bits.
- N, 4, number of data inputs (2..16).
- SELW, 2, select width; must satisfy 2^SELW >= N.
- STAGES, 1, register stages between input and output (legal values 1 or 2).
- OOR_ZERO, 1, out-of-range select policy: 1 = output zero word; 0 = repeat last stage-1 data word.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- in_bus  input  N*WIDTH  packed inputs; input i occupies bits [i*WIDTH +: WIDTH].
- sel  input  SELW  input select, sampled with in_valid.
- in_valid  input  1  beat present on in_bus/sel.
- stall  input  1  hold all stages; input beat not accepted.
- flush  input  1  invalidate all stages.
- out  output  WIDTH  selected word, registered.
- out_valid  output  1  out holds a valid beat.
- sel_err  output  1  beat at output had sel >= N.
- err_count  output  8  saturating count of accepted out-of-range beats.

Behaviour:
- All outputs are registered. Nothing combinational flows from inputs to outputs.
- Control priority per cycle: Reset > flush > stall > advance.
- Reset (sampled at the Clk edge): all stage data = 0, valid = 0, sel_err = 0, err_count = 0. Reset asserted mid-stream discards in-flight beats with no partial outputs. out_valid is 0 in the first cycle after Reset deasserts.
- Accept condition: a beat is accepted when in_valid=1, stall=0, flush=0 and Reset=0.
- Stage 1 on advance:
  - valid1 <= in_valid.
  - If in_valid=0: data1 and err1 are held, with valid1 = 0.
  - If in_valid=1 and sel < N: data1 <= in_bus[sel*WIDTH +: WIDTH], err1 <= 0.
  - If in_valid=1 and sel >= N: err1 <= 1. data1 <= 0 when OOR_ZERO=1; data1 keeps its previous value when OOR_ZERO=0.
- Stage 2 (STAGES=2 only): on advance, copies {data1, valid1, err1}.
- Outputs come from the last stage.
- Latency: accepted beat appears at out exactly STAGES cycles later, absent stall/flush.
- Stall: every stage holds data, valid and err. Inputs are ignored. A beat presented during stall is lost; the upstream stage is expected to hold it. err_count does not change.
- Flush: all valid and err bits are cleared to 0, data registers are cleared to 0, and the input beat that cycle is discarded. err_count is unchanged.
- Flush and stall in the same cycle: flush wins.
- err_count increments by 1 on each accepted beat with sel >= N, saturates at 255 and does not wrap. It is cleared only by Reset.
- When N = 2^SELW, out-of-range cannot occur: sel_err stays 0 and err_count stays 0.
- Back-to-back accepted beats produce one output per cycle, with no bubbles inserted.
- Elaboration must fail if STAGES is not 1 or 2, or if 2^SELW < N.

Test Plan:
- Basic select, defaults (WIDTH=32, N=4, STAGES=1): in_bus = {0x44444444, 0x33333333, 0x22222222, 0x11111111}, sel cycling 0,1,2,3 with in_valid=1 -> out = 0x11111111, 0x22222222, 0x33333333, 0x44444444 one cycle later each; out_valid=1 throughout; sel_err=0.
- Latency/stall, STAGES=2: accept sel=2 at cycle 0, stall=1 on cycles 1-2 -> out=0x33333333 with out_valid=1 first at cycle 4, not cycle 2. A beat with sel=3 presented during the stall never appears at out.
- Flush, STAGES=2: two beats in flight, flush=1 together with stall=1 -> next cycle out_valid=0 and out=0; no flushed beat ever emerges; err_count unchanged.
- Out-of-range, N=3, SELW=2:
  - OOR_ZERO=1: sel=3 -> out=0, sel_err=1, err_count=1.
  - OOR_ZERO=0: after a sel=1 beat (0x22222222), sel=3 -> out=0x22222222, sel_err=1.
- Saturation: 300 accepted beats with sel=3 (N=3) -> err_count reaches 255 and stays 255; a subsequent sel=0 beat gives sel_err=0.
- Reset mid-operation: Reset=1 for one cycle while stages hold valid beats and err_count=5 -> next cycle out=0, out_valid=0, sel_err=0, err_count=0. Normal operation resumes on the first accepted beat after Reset deasserts.
